// File: rtl/data_bus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | data_bus_arbiter: two-master round-robin arbiter for one req/gnt/rvalid     |
// | slave port, with a response watchdog.  Rev 1.0                              |
// +----------------------------------------------------------------------------+
module data_bus_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                m0_req_i,
  input  logic                m0_we_i,
  input  logic [DATA_W/8-1:0] m0_be_i,
  input  logic [ADDR_W-1:0]   m0_addr_i,
  input  logic [DATA_W-1:0]   m0_wdata_i,
  output logic                m0_gnt_o,
  output logic                m0_rvalid_o,
  output logic [DATA_W-1:0]   m0_rdata_o,
  output logic                m0_err_o,
  input  logic                m1_req_i,
  input  logic                m1_we_i,
  input  logic [DATA_W/8-1:0] m1_be_i,
  input  logic [ADDR_W-1:0]   m1_addr_i,
  input  logic [DATA_W-1:0]   m1_wdata_i,
  output logic                m1_gnt_o,
  output logic                m1_rvalid_o,
  output logic [DATA_W-1:0]   m1_rdata_o,
  output logic                m1_err_o,
  output logic                data_req_o,
  output logic                data_we_o,
  output logic [DATA_W/8-1:0] data_be_o,
  output logic [ADDR_W-1:0]   data_addr_o,
  output logic [DATA_W-1:0]   data_wdata_o,
  input  logic                data_gnt_i,
  input  logic                data_rvalid_i,
  input  logic [DATA_W-1:0]   data_rdata_i,
  output logic                owner_o,
  output logic                busy_o
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT_CYCLES);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_owner_q, last_owner_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

  logic any_req;
  logic winner;
  logic owner_req;
  logic sel;
  logic payload_en;
  logic gnt_fire;
  logic resp_fire;
  logic resp_err;

  always_comb begin
    any_req   = m0_req_i | m1_req_i;
    // On a tie the master that was not served last wins.
    winner    = (m0_req_i & m1_req_i) ? ~last_owner_q : m1_req_i;
    owner_req = owner_q ? m1_req_i : m0_req_i;
    sel       = (state_q == ST_IDLE) ? winner : owner_q;
    payload_en = ~rst_i & ((state_q != ST_IDLE) | any_req);

    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    tmo_cnt_d    = '0;
    gnt_fire     = 1'b0;
    resp_fire    = 1'b0;
    resp_err     = 1'b0;
    data_req_o   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          data_req_o = 1'b1;
          owner_d    = winner;
          if (data_gnt_i) begin
            gnt_fire = 1'b1;
            state_d  = ST_RESP;
          end else begin
            state_d  = ST_ADDR;
          end
        end
      end
      ST_ADDR: begin
        data_req_o = owner_req;
        if (!owner_req) begin
          state_d = ST_IDLE;
        end else if (data_gnt_i) begin
          gnt_fire = 1'b1;
          state_d  = ST_RESP;
        end
      end
      ST_RESP: begin
        tmo_cnt_d = (tmo_cnt_q == TMO_MAX) ? tmo_cnt_q : tmo_cnt_q + TMO_W'(1);
        if (data_rvalid_i) begin
          resp_fire    = 1'b1;
          last_owner_d = owner_q;
          state_d      = ST_IDLE;
        end else if (tmo_cnt_q == TMO_LAST) begin
          resp_fire    = 1'b1;
          resp_err     = 1'b1;
          last_owner_d = owner_q;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    data_req_o = data_req_o & ~rst_i;
    gnt_fire   = gnt_fire & ~rst_i;
    resp_fire  = resp_fire & ~rst_i;
    resp_err   = resp_err & ~rst_i;
  end

  always_comb begin
    data_we_o    = payload_en & (sel ? m1_we_i : m0_we_i);
    data_be_o    = payload_en ? (sel ? m1_be_i : m0_be_i) : '0;
    data_addr_o  = payload_en ? (sel ? m1_addr_i : m0_addr_i) : '0;
    data_wdata_o = payload_en ? (sel ? m1_wdata_i : m0_wdata_i) : '0;

    m0_gnt_o    = gnt_fire & ~sel;
    m1_gnt_o    = gnt_fire & sel;
    m0_rvalid_o = resp_fire & ~owner_q;
    m1_rvalid_o = resp_fire & owner_q;
    m0_err_o    = resp_err & ~owner_q;
    m1_err_o    = resp_err & owner_q;
    // Timeout responses carry zero data; the slave bus is only passed on a real rvalid.
    m0_rdata_o  = (resp_fire & ~resp_err & ~owner_q) ? data_rdata_i : '0;
    m1_rdata_o  = (resp_fire & ~resp_err & owner_q) ? data_rdata_i : '0;

    owner_o = owner_q;
    busy_o  = (state_q != ST_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      tmo_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      tmo_cnt_q    <= tmo_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_bus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_data_bus_arbiter: directed and random stimulus against a transaction   |
// | level reference of the two-master arbiter.  Rev 1.0                        |
// +----------------------------------------------------------------------------+
module tb_data_bus_arbiter;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [3:0]  m0_be, m1_be;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        d_req, d_we, s_gnt, s_rvalid;
  logic [3:0]  d_be;
  logic [31:0] d_addr, d_wdata, s_rdata;
  logic        owner, busy;

  always #5 clk = ~clk;

  data_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_i(clk), .rst_i(rst),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_be_i(m0_be), .m0_addr_i(m0_addr),
    .m0_wdata_i(m0_wdata), .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rvalid),
    .m0_rdata_o(m0_rdata), .m0_err_o(m0_err),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_be_i(m1_be), .m1_addr_i(m1_addr),
    .m1_wdata_i(m1_wdata), .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rvalid),
    .m1_rdata_o(m1_rdata), .m1_err_o(m1_err),
    .data_req_o(d_req), .data_we_o(d_we), .data_be_o(d_be), .data_addr_o(d_addr),
    .data_wdata_o(d_wdata), .data_gnt_i(s_gnt), .data_rvalid_i(s_rvalid),
    .data_rdata_i(s_rdata), .owner_o(owner), .busy_o(busy)
  );

  int errors = 0;
  int checks = 0;

  // Transaction-level reference: is a transaction open, has it been accepted by
  // the slave, who owns it, who was served last, and how long it has waited.
  bit have_txn, accepted, own, last_served;
  int age;

  logic [1:0]  e_gnt, e_rv, e_err;
  logic [31:0] e_rdata0, e_rdata1, e_addr, e_wdata;
  logic [3:0]  e_be;
  logic        e_req, e_we;

  logic [1:0]  obs_gnt, obs_rv, obs_err;
  logic [31:0] obs_rdata0, obs_addr;
  logic        obs_busy, obs_req;
  int          gnt_log[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit req_of(input bit m);
    return m ? m1_req : m0_req;
  endfunction

  function automatic bit pick();
    if (m0_req && m1_req) return !last_served;
    return m1_req;
  endfunction

  task automatic load_payload(input bit m);
    e_we    = m ? m1_we : m0_we;
    e_be    = m ? m1_be : m0_be;
    e_addr  = m ? m1_addr : m0_addr;
    e_wdata = m ? m1_wdata : m0_wdata;
  endtask

  task automatic model_expect();
    bit w;
    e_gnt = '0; e_rv = '0; e_err = '0; e_rdata0 = '0; e_rdata1 = '0;
    e_req = 0; e_we = 0; e_be = '0; e_addr = '0; e_wdata = '0;
    if (!rst) begin
      if (!have_txn) begin
        if (m0_req || m1_req) begin
          w = pick();
          e_req = 1;
          load_payload(w);
          if (s_gnt) e_gnt[w] = 1'b1;
        end
      end else if (!accepted) begin
        load_payload(own);
        e_req = req_of(own);
        if (req_of(own) && s_gnt) e_gnt[own] = 1'b1;
      end else begin
        load_payload(own);
        if (s_rvalid) begin
          e_rv[own] = 1'b1;
          if (own) e_rdata1 = s_rdata; else e_rdata0 = s_rdata;
        end else if (age == TMO - 1) begin
          e_rv[own]  = 1'b1;
          e_err[own] = 1'b1;
        end
      end
    end
  endtask

  task automatic model_advance();
    if (rst) begin
      have_txn = 0; accepted = 0; own = 0; last_served = 1; age = 0;
    end else if (!have_txn) begin
      if (m0_req || m1_req) begin
        own = pick(); have_txn = 1; accepted = s_gnt; age = 0;
      end
    end else if (!accepted) begin
      if (!req_of(own)) have_txn = 0;
      else if (s_gnt) begin accepted = 1; age = 0; end
    end else if (s_rvalid || age == TMO - 1) begin
      have_txn = 0; accepted = 0; last_served = own;
    end else begin
      age++;
    end
  endtask

  // One clock cycle: check all outputs against the model, then advance both.
  task automatic step();
    #1;
    model_expect();
    chk("m0_gnt", m0_gnt, e_gnt[0]);
    chk("m1_gnt", m1_gnt, e_gnt[1]);
    chk("m0_rvalid", m0_rvalid, e_rv[0]);
    chk("m1_rvalid", m1_rvalid, e_rv[1]);
    chk("m0_err", m0_err, e_err[0]);
    chk("m1_err", m1_err, e_err[1]);
    chk("m0_rdata", m0_rdata, e_rdata0);
    chk("m1_rdata", m1_rdata, e_rdata1);
    chk("data_req", d_req, e_req);
    chk("data_payload", {d_we, d_be, d_addr, d_wdata[26:0]}, {e_we, e_be, e_addr, e_wdata[26:0]});
    chk("data_wdata_hi", d_wdata[31:27], e_wdata[31:27]);
    chk("owner", owner, own);
    chk("busy", busy, have_txn);
    obs_gnt = {m1_gnt, m0_gnt}; obs_rv = {m1_rvalid, m0_rvalid}; obs_err = {m1_err, m0_err};
    obs_rdata0 = m0_rdata; obs_addr = d_addr; obs_busy = busy; obs_req = d_req;
    if (m0_gnt) gnt_log.push_back(0);
    if (m1_gnt) gnt_log.push_back(1);
    @(posedge clk);
    model_advance();
    #1;
  endtask

  task automatic quiet();
    m0_req = 0; m0_we = 0; m0_be = '0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_be = '0; m1_addr = '0; m1_wdata = '0;
    s_gnt = 0; s_rvalid = 0; s_rdata = '0;
  endtask

  initial begin
    int n;
    int rv_pct;
    quiet();
    rst = 1;
    have_txn = 0; accepted = 0; own = 0; last_served = 1; age = 0;
    @(posedge clk); #1;
    step(); step();
    rst = 0;
    step();
    chk("reset_busy", obs_busy, 1'b0);
    chk("reset_owner", owner, 1'b0);

    // Tie and fairness: four back-to-back ties from reset.
    gnt_log.delete();
    m0_req = 1; m0_addr = 32'h100; m1_req = 1; m1_addr = 32'h200; s_gnt = 1;
    for (int t = 0; t < 4; t++) begin
      s_rvalid = 0; step();
      chk("fair_owner", owner, t[0]);
      s_rvalid = 1; s_rdata = 32'h1000 + t; step();
    end
    chk("fair_count", gnt_log.size(), 4);
    for (int t = 0; t < 4 && t < gnt_log.size(); t++) chk("fair_order", gnt_log[t], t % 2);
    quiet(); step();

    // Single read by m0 with same-cycle grant.
    m0_req = 1; m0_addr = 32'h0000_0010; s_gnt = 1;
    step();
    chk("sr_gnt", obs_gnt, 2'b01);
    m0_req = 0; s_gnt = 0; s_rvalid = 1; s_rdata = 32'hDEAD_BEEF;
    step();
    chk("sr_rvalid", obs_rv, 2'b01);
    chk("sr_rdata", obs_rdata0, 32'hDEAD_BEEF);
    chk("sr_err", obs_err, 2'b00);
    quiet(); step();

    // Grant stall with a competing late request.
    m0_req = 1; m0_addr = 32'hA0A0_0000;
    step();
    m1_req = 1; m1_addr = 32'hB0B0_0000;
    step(); chk("stall_addr1", obs_addr, 32'hA0A0_0000);
    step(); chk("stall_addr2", obs_addr, 32'hA0A0_0000);
    s_gnt = 1;
    step(); chk("stall_gnt", obs_gnt, 2'b01);
    m0_req = 0; s_gnt = 0; s_rvalid = 1;
    step();
    s_rvalid = 0; s_gnt = 1;
    step(); chk("stall_next_gnt", obs_gnt, 2'b10);
    m1_req = 0; s_gnt = 0; s_rvalid = 1;
    step();
    quiet(); step();

    // Timeout on an m1 write.
    m1_req = 1; m1_we = 1; m1_be = 4'hF; m1_addr = 32'h40; m1_wdata = 32'h1234_5678; s_gnt = 1;
    step(); chk("tmo_gnt", obs_gnt, 2'b10);
    m1_req = 0; s_gnt = 0;
    n = 0;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (obs_rv != 2'b00) begin n = c; break; end
    end
    chk("tmo_latency", n, TMO);
    chk("tmo_rvalid", obs_rv, 2'b10);
    chk("tmo_err", obs_err, 2'b10);
    step(); chk("tmo_idle_after", obs_busy, 1'b0);

    // Stray rvalid while idle.
    s_rvalid = 1; s_rdata = 32'h5555_AAAA;
    step(); chk("stray_rv", obs_rv, 2'b00);
    quiet();

    // rvalid arriving in the timeout cycle.
    m0_req = 1; m0_addr = 32'h80; s_gnt = 1;
    step();
    m0_req = 0; s_gnt = 0;
    for (int c = 1; c < TMO; c++) step();
    s_rvalid = 1; s_rdata = 32'hCAFE_F00D;
    step();
    chk("late_rv", obs_rv, 2'b01);
    chk("late_err", obs_err, 2'b00);
    chk("late_rdata", obs_rdata0, 32'hCAFE_F00D);
    quiet(); step();

    // m0 abandons its request before grant.
    m0_req = 1; m0_addr = 32'hC0;
    step();
    m0_req = 0;
    step(); chk("drop_gnt", obs_gnt, 2'b00); chk("drop_req", obs_req, 1'b0);
    step(); chk("drop_idle", obs_busy, 1'b0);

    // Reset while a response is pending; the following tie goes to m0.
    m1_req = 1; m1_addr = 32'hE0; s_gnt = 1;
    step();
    m1_req = 0; s_gnt = 0; rst = 1; s_rvalid = 1; s_rdata = 32'h7777_7777;
    step(); chk("rst_no_rv", obs_rv, 2'b00);
    rst = 0; s_rvalid = 0;
    step(); chk("rst_busy", obs_busy, 1'b0);
    m0_req = 1; m1_req = 1; s_gnt = 1;
    step(); chk("rst_tie", obs_gnt, 2'b01);
    quiet(); s_rvalid = 1; step();
    quiet(); step();

    // Random traffic with occasional resets and varying slave latency.
    for (int c = 0; c < 3000; c++) begin
      rv_pct   = (c / 500) % 2 ? 3 : 35;
      m0_req   = ($urandom_range(99) < 60);
      m1_req   = ($urandom_range(99) < 60);
      m0_we    = $urandom_range(1); m1_we = $urandom_range(1);
      m0_be    = 4'($urandom); m1_be = 4'($urandom);
      m0_addr  = $urandom; m1_addr = $urandom;
      m0_wdata = $urandom; m1_wdata = $urandom;
      s_gnt    = ($urandom_range(99) < 50);
      s_rvalid = ($urandom_range(99) < rv_pct);
      s_rdata  = $urandom;
      rst      = ($urandom_range(199) == 0);
      step();
    end
    rst = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/data_bus_arbiter.md
Name: data_bus_arbiter

Overview:
- Two-master, one-slave arbiter for the core data bus. It shares the single data_ram port between the core load/store unit (master 0) and a secondary master (master 1), such as a debug/loader DMA.
- Req/gnt/rvalid protocol on all sides. One outstanding transaction at a time.
- Round-robin fairness.
- A response watchdog returns an error response if the slave never asserts rvalid.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; byte-enable width is DATA_W/8.
- TIMEOUT_CYCLES, 16, number of cycles to wait for rvalid after gnt before an error response is forced (must be >=1).

Ports:
clk_i  in  1  clock; all logic rising-edge.
rst_i  in  1  synchronous reset, active-high.
mN_req_i  in  1  request from master N (N=0,1).
mN_we_i  in  1  write enable.
mN_be_i  in  DATA_W/8  byte enables.
mN_addr_i  in  ADDR_W  address.
mN_wdata_i  in  DATA_W  write data.
mN_gnt_o  out  1  grant pulse to master N.
mN_rvalid_o  out  1  response valid to master N.
mN_rdata_o  out  DATA_W  read data to master N.
mN_err_o  out  1  error flag, qualified by mN_rvalid_o.
data_req_o  out  1  request to slave.
data_we_o  out  1  slave write enable.
data_be_o  out  DATA_W/8  slave byte enables.
data_addr_o  out  ADDR_W  slave address.
data_wdata_o  out  DATA_W  slave write data.
data_gnt_i  in  1  slave grant.
data_rvalid_i  in  1  slave response valid (for reads and writes).
data_rdata_i  in  DATA_W  slave read data.
owner_o  out  1  current/last owner index.
busy_o  out  1  high when state is not IDLE.

Behaviour:
- States are IDLE, ADDR and RESP. Registers: state, owner, last_owner, tmo_cnt.
- Reset: state=IDLE, owner=0, last_owner=1 (so m0 wins the first tie), tmo_cnt=0.
  - All gnt, rvalid and err outputs are 0 and data_req_o is 0.
  - rdata outputs are 0, data_* payload is 0.
  - busy_o is 0.
- Winner selection in IDLE (combinational):
  - Only one master requesting: that master wins.
  - Both requesting: the master != last_owner wins.
- Slave payload mux: data_we/be/addr/wdata_o follow the winner in IDLE and follow the owner in ADDR/RESP.
  - data_req_o = (IDLE & any req) | (ADDR & owner's req).
  - data_req_o is 0 in RESP.
- IDLE:
  - Owner is latched to the winner whenever any req is high.
  - If data_gnt_i is also high: mW_gnt_o=1 in the same cycle and the next state is RESP.
  - Otherwise the next state is ADDR.
- ADDR:
  - The selection is frozen; a newly arriving request from the other master must not steal the bus.
  - On data_gnt_i: mOwner_gnt_o=1 and the next state is RESP.
  - If the owner drops req before gnt (protocol violation): data_req_o drops that cycle, no gnt, next state is IDLE, last_owner is unchanged.
- RESP:
  - tmo_cnt increments each cycle; it is cleared on entry.
  - On data_rvalid_i:
    - mOwner_rvalid_o=1 and mOwner_rdata_o=data_rdata_i in the same cycle (combinational pass-through).
    - err=0, last_owner<=owner, next state is IDLE.
  - If tmo_cnt==TIMEOUT_CYCLES-1 without rvalid:
    - mOwner_rvalid_o=1, err=1, rdata=0.
    - last_owner<=owner, next state is IDLE.
  - rvalid and timeout in the same cycle: the rvalid wins (err=0).
- Stray data_rvalid_i in IDLE or ADDR is ignored; no master sees it.
- The non-owner always sees gnt=0, rvalid=0, rdata=0.
- IDLE→RESP→IDLE costs at least 1 idle cycle between transactions. There is no back-to-back issue in the RESP cycle.
- Synchronous rst_i mid-transaction:
  - State returns to IDLE the next cycle with no response delivered.
  - Outputs return to their reset values.
- tmo_cnt width is $clog2(TIMEOUT_CYCLES+1); it saturates and never wraps.

Test Plan:
- Single read: m0 reads 0x0000_0010 with gnt same cycle and rvalid 1 cycle later, rdata=0xDEAD_BEEF. Required response: m0_gnt_o pulse at cycle 0, m0_rvalid_o with 0xDEAD_BEEF at cycle 1, m1 outputs all 0.
- Tie and fairness: m0 and m1 hold req for 4 transactions from reset. Required response: grant order m0,m1,m0,m1, with owner_o toggling accordingly.
- Grant stall: m0 requests and the slave withholds gnt for 3 cycles; m1 raises req in cycle 1. Required response: data_addr_o stays at m0's address and m0 is granted at cycle 3; m1 is granted on the next transaction.
- Timeout (TIMEOUT_CYCLES=16): m1 writes with be=0xF, slave grants and never returns rvalid. Required response: m1_rvalid_o=1, m1_err_o=1, rdata=0 exactly 16 cycles after gnt; busy_o=0 the following cycle.
- Edge cases:
  - Stray data_rvalid_i in IDLE produces no master rvalid.
  - rvalid arriving in the timeout cycle gives err=0.
  - m0 dropping req in ADDR gives no gnt and a return to IDLE.
- Reset mid-transaction: rst_i is asserted 1 cycle in RESP. Required response: no rvalid is delivered, busy_o=0 next cycle, and the next tie is won by m0.
